// File: rtl/wishbone_ram_target.sv
// Pipelined Wishbone B4 responder in front of a word-addressed on-chip RAM.
// Fixed-latency ACK/ERR termination, outstanding-request bound via STALL.
module wishbone_ram_target #(
  parameter int AddressWidth   = 16,
  parameter int DataWidth      = 32,
  parameter int Granularity    = 8,
  parameter int TGDWidth       = 1,
  parameter int TGAWidth       = 1,
  parameter int TGCWidth       = 1,
  parameter int MemWords       = 256,
  parameter int BaseAddress    = 0,
  parameter int Latency        = 1,
  parameter int MaxOutstanding = 2,
  localparam int SELWidth      = DataWidth / Granularity
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic                    we_i,
  input  logic [AddressWidth-1:0] addr_i,
  input  logic [SELWidth-1:0]     sel_i,
  input  logic [DataWidth-1:0]    dat_i,
  input  logic [TGDWidth-1:0]     tgd_i,
  input  logic                    lock_i,
  input  logic [2:0]              cti_i,
  input  logic [1:0]              bte_i,
  input  logic [TGAWidth-1:0]     tga_i,
  input  logic [TGCWidth-1:0]     tgc_i,
  output logic                    stall_o,
  output logic                    ack_o,
  output logic                    err_o,
  output logic                    rty_o,
  output logic [DataWidth-1:0]    dat_o,
  output logic [TGDWidth-1:0]     tgd_o
);

  localparam int IdxWidth = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam int OutWidth = (MaxOutstanding > 0) ? $clog2(MaxOutstanding + 1) : 1;
  localparam logic [AddressWidth:0] BaseW     = (AddressWidth + 1)'(BaseAddress);
  localparam logic [AddressWidth:0] MemWordsW = (AddressWidth + 1)'(MemWords);
  localparam logic [OutWidth-1:0]   MaxOutW   = OutWidth'(MaxOutstanding);

  logic [DataWidth-1:0] mem_q [MemWords];

  logic [Latency-1:0]   ack_q, ack_d;
  logic [Latency-1:0]   err_q, err_d;
  logic [DataWidth-1:0] dat_q [Latency];
  logic [DataWidth-1:0] dat_d [Latency];
  logic [TGDWidth-1:0]  tgd_q [Latency];
  logic [TGDWidth-1:0]  tgd_d [Latency];
  logic [OutWidth-1:0]  out_q, out_d;

  logic [AddressWidth:0] off_s;
  logic                  in_win_s;
  logic [IdxWidth-1:0]   idx_s;
  logic [DataWidth-1:0]  rd_word_s;
  logic                  accept_s;
  logic                  term_s;
  logic                  wr_en_s;
  logic                  unused_s;

  // Unsigned subtraction one bit wider than ADDR so addresses below the base wrap out of window.
  assign off_s     = {1'b0, addr_i} - BaseW;
  assign in_win_s  = (off_s < MemWordsW);
  assign idx_s     = off_s[IdxWidth-1:0];
  assign rd_word_s = mem_q[idx_s];

  assign term_s   = ack_o | err_o;
  assign stall_o  = (out_q == MaxOutW) & ~term_s;
  assign accept_s = cyc_i & stb_i & ~stall_o;
  assign wr_en_s  = accept_s & in_win_s & we_i;

  assign ack_o = ack_q[Latency-1];
  assign err_o = err_q[Latency-1];
  assign dat_o = dat_q[Latency-1];
  assign tgd_o = tgd_q[Latency-1];
  assign rty_o = 1'b0;

  assign unused_s = ^{lock_i, cti_i, bte_i, tga_i, tgc_i};

  // RAM write port: byte-lane masked, contents deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      for (int i = 0; i < SELWidth; i++) begin
        if (sel_i[i]) begin
          mem_q[idx_s][i*Granularity +: Granularity] <= dat_i[i*Granularity +: Granularity];
        end
      end
    end
  end

  // Termination pipeline next state; dropping CYC flushes every stage.
  always_comb begin
    ack_d = '0;
    err_d = '0;
    for (int i = 0; i < Latency; i++) begin
      dat_d[i] = '0;
      tgd_d[i] = '0;
    end
    if (cyc_i) begin
      ack_d[0] = accept_s & in_win_s;
      err_d[0] = accept_s & ~in_win_s;
      dat_d[0] = (accept_s & in_win_s & ~we_i) ? rd_word_s : '0;
      tgd_d[0] = accept_s ? tgd_i : '0;
      for (int i = 1; i < Latency; i++) begin
        ack_d[i] = ack_q[i-1];
        err_d[i] = err_q[i-1];
        dat_d[i] = dat_q[i-1];
        tgd_d[i] = tgd_q[i-1];
      end
    end else begin
      ack_d = '0;
      err_d = '0;
    end
  end

  // Outstanding-request count; a simultaneous accept and termination cancel.
  always_comb begin
    out_d = out_q;
    if (!cyc_i) begin
      out_d = '0;
    end else begin
      case ({accept_s, term_s})
        2'b10:   out_d = out_q + OutWidth'(1);
        2'b01:   out_d = out_q - OutWidth'(1);
        default: out_d = out_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q <= '0;
      err_q <= '0;
      out_q <= '0;
      for (int i = 0; i < Latency; i++) begin
        dat_q[i] <= '0;
        tgd_q[i] <= '0;
      end
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      out_q <= out_d;
      for (int i = 0; i < Latency; i++) begin
        dat_q[i] <= dat_d[i];
        tgd_q[i] <= tgd_d[i];
      end
    end
  end

endmodule

// File: tb/tb_wishbone_ram_target.sv
// Randomized self-checking bench: two targets (Latency 1 / 2) share one initiator
// and are compared every cycle against a schedule-based behavioural model.
module tb_wishbone_ram_target;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        cyc, stb, we;
  logic [15:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdat;
  logic [0:0]  tgd;
  logic        lock;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [0:0]  tga, tgc;

  logic [1:0]  stall_w, ack_w, err_w, rty_w;
  logic [31:0] dat_w [2];
  logic [0:0]  tgd_w [2];

  int n_checks = 0;
  int n_errors = 0;

  // Model: RAM image plus completions scheduled by due cycle (slot = cycle mod 8).
  logic [31:0] mem_m [2][256];
  bit          sv [2][8];
  bit          se [2][8];
  logic [31:0] sd [2][8];
  logic [0:0]  st [2][8];
  int          outc [2];
  int          t = 0;

  always #5 clk = ~clk;

  wishbone_ram_target #(.BaseAddress(256), .Latency(1), .MaxOutstanding(2)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .cyc_i(cyc), .stb_i(stb), .we_i(we), .addr_i(addr),
    .sel_i(sel), .dat_i(wdat), .tgd_i(tgd), .lock_i(lock), .cti_i(cti), .bte_i(bte),
    .tga_i(tga), .tgc_i(tgc), .stall_o(stall_w[0]), .ack_o(ack_w[0]), .err_o(err_w[0]),
    .rty_o(rty_w[0]), .dat_o(dat_w[0]), .tgd_o(tgd_w[0]));

  wishbone_ram_target #(.BaseAddress(0), .Latency(2), .MaxOutstanding(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .cyc_i(cyc), .stb_i(stb), .we_i(we), .addr_i(addr),
    .sel_i(sel), .dat_i(wdat), .tgd_i(tgd), .lock_i(lock), .cti_i(cti), .bte_i(bte),
    .tga_i(tga), .tgc_i(tgc), .stall_o(stall_w[1]), .ack_o(ack_w[1]), .err_o(err_w[1]),
    .rty_o(rty_w[1]), .dat_o(dat_w[1]), .tgd_o(tgd_w[1]));

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int mo_of(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int base_of(int k);
    return (k == 0) ? 256 : 0;
  endfunction

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      outc[k] = 0;
      for (int s = 0; s < 8; s++) sv[k][s] = 1'b0;
    end
  endtask

  task automatic check_all_zero(string tag);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("%s ack%0d", tag, k),   ack_w[k],   64'd0);
      check_eq($sformatf("%s err%0d", tag, k),   err_w[k],   64'd0);
      check_eq($sformatf("%s stall%0d", tag, k), stall_w[k], 64'd0);
      check_eq($sformatf("%s dat%0d", tag, k),   dat_w[k],   64'd0);
      check_eq($sformatf("%s tgd%0d", tag, k),   tgd_w[k],   64'd0);
    end
  endtask

  // One bus cycle: compare outputs at the falling edge, advance the model, then pass the rising edge.
  task automatic tick();
    int   slot, ns, off;
    bit   term, xstall, xack, xerr;
    logic [31:0] xdat;
    logic [0:0]  xtgd;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      slot   = t % 8;
      term   = sv[k][slot];
      xack   = term && !se[k][slot];
      xerr   = term && se[k][slot];
      xstall = (outc[k] == mo_of(k)) && !term;
      xdat   = xack ? sd[k][slot] : 32'd0;
      xtgd   = term ? st[k][slot] : 1'b0;
      check_eq($sformatf("ack%0d c%0d", k, t),   ack_w[k],   xack);
      check_eq($sformatf("err%0d c%0d", k, t),   err_w[k],   xerr);
      check_eq($sformatf("stall%0d c%0d", k, t), stall_w[k], xstall);
      check_eq($sformatf("rty%0d c%0d", k, t),   rty_w[k],   64'd0);
      check_eq($sformatf("dat%0d c%0d", k, t),   dat_w[k],   xdat);
      check_eq($sformatf("tgd%0d c%0d", k, t),   tgd_w[k],   xtgd);
      if (!cyc) begin
        outc[k] = 0;
        for (int s = 0; s < 8; s++) sv[k][s] = 1'b0;
      end else begin
        if (term) begin
          sv[k][slot] = 1'b0;
          outc[k]--;
        end
        if (stb && !xstall) begin
          off = int'(addr) - base_of(k);
          ns  = (t + lat_of(k)) % 8;
          sv[k][ns] = 1'b1;
          st[k][ns] = tgd;
          se[k][ns] = !(off >= 0 && off < 256);
          sd[k][ns] = 32'd0;
          if (!se[k][ns]) begin
            if (we) begin
              for (int b = 0; b < 4; b++)
                if (sel[b]) mem_m[k][off][8*b +: 8] = wdat[8*b +: 8];
            end else begin
              sd[k][ns] = mem_m[k][off];
            end
          end
          outc[k]++;
        end
      end
    end
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic req(bit w, logic [15:0] a, logic [3:0] s, logic [31:0] d, logic [0:0] g, int n);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; sel = s; wdat = d; tgd = g;
    repeat (n) tick();
  endtask

  task automatic idle(bit c, int n);
    cyc = c; stb = 1'b0; we = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 16'h0110; sel = 4'hF; wdat = 32'd0; tgd = 1'b1;
    lock = 1'b0; cti = 3'd0; bte = 2'd0; tga = 1'b0; tgc = 1'b0;
    #3;
    check_all_zero("reset0");
    repeat (2) begin
      @(negedge clk);
      check_all_zero("reset_hold");
    end
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0;
    rst_ni = 1'b1;
    model_clear();

    // Preload every word of both windows; each write is held two cycles so the stalling target takes it.
    for (int a = 0; a < 512; a++) req(1'b1, 16'(a), 4'hF, $urandom, 1'(a), 2);
    idle(1'b1, 3);

    // Write then immediate readback in both windows.
    req(1'b1, 16'h0110, 4'hF, 32'hDEADBEEF, 1'b0, 1);
    req(1'b0, 16'h0110, 4'hF, 32'd0, 1'b1, 2);
    req(1'b1, 16'h0010, 4'hF, 32'hDEADBEEF, 1'b0, 2);
    req(1'b0, 16'h0010, 4'hF, 32'd0, 1'b1, 2);
    idle(1'b1, 3);

    // Byte lanes.
    req(1'b1, 16'h0120, 4'hF, 32'h11223344, 1'b0, 2);
    req(1'b1, 16'h0120, 4'b0101, 32'hAABBCCDD, 1'b1, 2);
    req(1'b0, 16'h0120, 4'hF, 32'd0, 1'b0, 2);
    req(1'b1, 16'h0020, 4'hF, 32'h11223344, 1'b0, 2);
    req(1'b1, 16'h0020, 4'b1010, 32'hAABBCCDD, 1'b1, 2);
    req(1'b0, 16'h0020, 4'hF, 32'd0, 1'b0, 2);
    idle(1'b1, 3);

    // Window edges, including below-base wraparound and the last word.
    req(1'b0, 16'h0200, 4'hF, 32'd0, 1'b1, 2);
    req(1'b1, 16'h00FF, 4'hF, 32'h55AA55AA, 1'b0, 2);
    req(1'b0, 16'h00FF, 4'hF, 32'd0, 1'b1, 2);
    req(1'b0, 16'h01FF, 4'hF, 32'd0, 1'b0, 2);
    req(1'b0, 16'h0100, 4'hF, 32'd0, 1'b1, 2);
    req(1'b0, 16'hFFFF, 4'hF, 32'd0, 1'b0, 2);
    idle(1'b1, 3);

    // Back-to-back reads with STB held: tags 0,1,0,1.
    for (int i = 0; i < 4; i++) req(1'b0, 16'(16'h0030 + i), 4'hF, 32'd0, 1'(i), 1);
    idle(1'b1, 4);

    // Abort: two writes, then CYC drops; readback later.
    req(1'b1, 16'h0140, 4'hF, 32'hCAFEF00D, 1'b0, 1);
    req(1'b1, 16'h0141, 4'hF, 32'h0BADC0DE, 1'b1, 1);
    idle(1'b0, 4);
    req(1'b0, 16'h0140, 4'hF, 32'd0, 1'b0, 2);
    req(1'b0, 16'h0141, 4'hF, 32'd0, 1'b1, 2);
    req(1'b1, 16'h0040, 4'hF, 32'h12345678, 1'b0, 1);
    idle(1'b0, 4);
    req(1'b0, 16'h0040, 4'hF, 32'd0, 1'b1, 2);
    idle(1'b1, 3);

    // Asynchronous reset mid-cycle with a termination showing.
    req(1'b0, 16'h0110, 4'hF, 32'd0, 1'b1, 1);
    cyc = 1'b0; stb = 1'b0;
    #1;
    rst_ni = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_clear();
    @(negedge clk);
    check_all_zero("rst_low");
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    req(1'b0, 16'h0110, 4'hF, 32'd0, 1'b0, 2);
    idle(1'b1, 4);

    // Random traffic over both windows and the surrounding error space.
    for (int i = 0; i < 1500; i++) begin
      cyc  = ($urandom_range(0, 15) != 0);
      stb  = ($urandom_range(0, 3) != 0);
      we   = 1'($urandom_range(0, 1));
      addr = 16'(16'h00C0 + $urandom_range(0, 16'h017F));
      sel  = 4'($urandom_range(0, 15));
      wdat = $urandom;
      tgd  = 1'($urandom_range(0, 1));
      lock = 1'($urandom_range(0, 1));
      cti  = 3'($urandom_range(0, 7));
      tick();
    end
    idle(1'b1, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
